// File: rtl/board_pkg.sv
// Shared types and sizes for the match-3 board sequencing logic.
package board_pkg;

    localparam int BOARD_DIM  = 8;
    localparam int CELL_BITS  = 3;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * CELL_BITS;
    localparam int SCORE_W    = 16;
    localparam int COMBO_W    = 4;
    localparam int COUNT_W    = 7;
    localparam int PROD_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_UNDO,
        ST_CLEAR,
        ST_REFRESH,
        ST_FILL,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    // Score accumulation clamps at the top of the score range.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [PROD_W-1:0]  b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W + 1 - PROD_W){1'b0}}, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Per-state wait counter; expired flags the last permitted cycle of a wait state.
module wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] elapsed;

    // clear marks the first cycle of a new state, so that cycle counts as zero.
    assign elapsed = clear ? '0 : count;
    assign expired = enable && (elapsed >= CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= elapsed + 1'b1;
        end
    end

endmodule

// File: rtl/board_sequencer.sv
// Move sequencer: swap check, clear/refresh/fill cascade, combo and score tracking.
//   state      | meaning
//   IDLE       | waiting for a swap
//   CHECK      | match detector evaluating the board
//   UNDO       | no match on first check, revert swap
//   CLEAR      | eliminating marked cells
//   REFRESH    | gravity/compaction running
//   FILL       | refilling empty cells
//   DONE       | cascade finished, board stable
//   ERROR      | wait timeout, held until reset
module board_sequencer
    import board_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_COMBO      = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               match_start,
    input  logic               match_done,
    input  logic               match_found,
    input  logic [COUNT_W-1:0] match_count,
    output logic               clear_start,
    input  logic               clear_done,
    output logic               ok_to_refresh,
    input  logic               refreshed,
    output logic               fill_start,
    input  logic               fill_done,
    output logic               swap_undo,
    output logic               settle_done,
    output logic               busy,
    output logic [COMBO_W-1:0] combo,
    output logic [SCORE_W-1:0] score,
    output logic               error
);

    seq_state_t         state;
    logic               timer_clr;
    logic               wait_en;
    logic               expired;
    logic [COMBO_W-1:0] combo_next;
    logic [PROD_W-1:0]  product;

    assign wait_en = (state == ST_CHECK) || (state == ST_CLEAR) ||
                     (state == ST_REFRESH) || (state == ST_FILL);
    assign busy    = !((state == ST_IDLE) || (state == ST_ERROR));

    assign combo_next = (combo >= COMBO_W'(MAX_COMBO)) ? COMBO_W'(MAX_COMBO) : combo + 1'b1;
    assign product    = PROD_W'(match_count) * PROD_W'(combo_next);

    wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clr),
        .enable  (wait_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            swap_ack      <= 1'b0;
            match_start   <= 1'b0;
            clear_start   <= 1'b0;
            ok_to_refresh <= 1'b0;
            fill_start    <= 1'b0;
            swap_undo     <= 1'b0;
            settle_done   <= 1'b0;
            combo         <= '0;
            score         <= '0;
            error         <= 1'b0;
            timer_clr     <= 1'b0;
        end else begin
            swap_ack    <= 1'b0;
            match_start <= 1'b0;
            clear_start <= 1'b0;
            fill_start  <= 1'b0;
            swap_undo   <= 1'b0;
            settle_done <= 1'b0;
            timer_clr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (swap_req) begin
                        state       <= ST_CHECK;
                        swap_ack    <= 1'b1;
                        match_start <= 1'b1;
                        combo       <= '0;
                        timer_clr   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    // A done arriving alongside its own start pulse is stale.
                    if (match_done && !match_start) begin
                        timer_clr <= 1'b1;
                        if (match_found) begin
                            state       <= ST_CLEAR;
                            clear_start <= 1'b1;
                            combo       <= combo_next;
                            score       <= sat_add(score, product);
                        end else if (combo == '0) begin
                            state     <= ST_UNDO;
                            swap_undo <= 1'b1;
                        end else begin
                            state       <= ST_DONE;
                            settle_done <= 1'b1;
                        end
                    end else if (expired) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clear_done && !clear_start) begin
                        state         <= ST_REFRESH;
                        ok_to_refresh <= 1'b1;
                        timer_clr     <= 1'b1;
                    end else if (expired) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
                ST_REFRESH: begin
                    if (refreshed) begin
                        state         <= ST_FILL;
                        ok_to_refresh <= 1'b0;
                        fill_start    <= 1'b1;
                        timer_clr     <= 1'b1;
                    end else if (expired) begin
                        state         <= ST_ERROR;
                        ok_to_refresh <= 1'b0;
                        error         <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_done && !fill_start) begin
                        state       <= ST_CHECK;
                        match_start <= 1'b1;
                        timer_clr   <= 1'b1;
                    end else if (expired) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
                ST_UNDO, ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERROR: begin
                    error <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
